// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants, encodings and FSM states for the cache set controller
package cache_pkg;

  localparam int TAG_W  = 24;
  localparam int IDX_W  = 6;
  localparam int OFF_W  = 6;
  localparam int WAYS   = 8;
  localparam int WAY_W  = 3;
  localparam int SETS   = 1 << IDX_W;
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam int BLK_W  = 512;

  typedef enum logic [1:0] {
    SZ_8  = 2'd0,
    SZ_16 = 2'd1,
    SZ_32 = 2'd2,
    SZ_64 = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WAIT_SET,
    ST_RESP,
    ST_FETCH,
    ST_VICTIM,
    ST_FILL,
    ST_WAIT_FILL
  } ctrl_state_e;

  // Index of the lowest-numbered zero bit; caller guarantees at least one exists.
  function automatic logic [WAY_W-1:0] lowest_clear(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] r;
    r = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!v[i]) r = WAY_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_victim_sel.sv
// rtl/clock_victim_sel.sv - per-set valid/ref/hand storage and clock-algorithm victim choice
// One sweep step per cycle while start_i is high; victim_valid_o marks the deciding cycle.
module clock_victim_sel
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             hit_touch_i,
  input  logic [WAY_W-1:0] hit_way_i,
  input  logic             fill_touch_i,
  input  logic [WAY_W-1:0] fill_way_i,
  input  logic             start_i,
  output logic [WAY_W-1:0] victim_o,
  output logic             victim_valid_o
);

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  ref_q   [SETS];
  logic [WAY_W-1:0] hand_q  [SETS];

  logic [WAYS-1:0]  valid_row, ref_row, valid_d, ref_d;
  logic [WAY_W-1:0] hand_row, hand_d;

  assign valid_row = valid_q[idx_i];
  assign ref_row   = ref_q[idx_i];
  assign hand_row  = hand_q[idx_i];

  // Only the addressed set changes in any cycle, so next-state is computed per row.
  always_comb begin
    valid_d        = valid_row;
    ref_d          = ref_row;
    hand_d         = hand_row;
    victim_o       = hand_row;
    victim_valid_o = 1'b0;
    if (start_i) begin
      if (valid_row != '1) begin
        victim_o       = lowest_clear(valid_row);
        victim_valid_o = 1'b1;
      end else if (ref_row[hand_row]) begin
        ref_d[hand_row] = 1'b0;
        hand_d          = hand_row + 1'b1;
      end else begin
        victim_valid_o = 1'b1;
        hand_d         = hand_row + 1'b1;
      end
    end
    if (hit_touch_i) ref_d[hit_way_i] = 1'b1;
    if (fill_touch_i) begin
      valid_d[fill_way_i] = 1'b1;
      ref_d[fill_way_i]   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ref_q[s]   <= '0;
        hand_q[s]  <= '0;
      end
    end else begin
      valid_q[idx_i] <= valid_d;
      ref_q[idx_i]   <= ref_d;
      hand_q[idx_i]  <= hand_d;
    end
  end

endmodule

// File: rtl/cache_set_ctrl.sv
// rtl/cache_set_ctrl.sv - request sequencer for the 8-way set datapath with miss fill and replay
module cache_set_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [35:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_miss,
  output logic              set_en,
  output logic              set_we,
  output logic              set_force,
  output logic [2:0]        set_way,
  output logic [23:0]       set_tag,
  output logic [5:0]        set_idx,
  output logic [5:0]        set_off,
  output logic [1:0]        set_size,
  output logic [63:0]       set_wdata,
  output logic [511:0]      set_fill,
  input  logic              set_done,
  input  logic              set_hit,
  input  logic [2:0]        set_hit_way,
  input  logic [63:0]       set_rdata,
  output logic              mem_req,
  output logic [29:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [511:0]      mem_rdata
);

  ctrl_state_e       state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  size_e             size_q, size_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [BLK_W-1:0]  fill_q, fill_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              miss_q, miss_d;
  logic              replay_q, replay_d;

  logic [WAY_W-1:0]  vsel_way;
  logic              vsel_valid;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fill_d   = fill_q;
    victim_d = victim_q;
    miss_d   = miss_q;
    replay_d = replay_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          size_d   = size_e'(req_size);
          wdata_d  = req_wdata;
          miss_d   = 1'b0;
          replay_d = 1'b0;
          state_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = ST_WAIT_SET;
      ST_WAIT_SET: begin
        if (set_done) begin
          rdata_d = set_rdata;
          // A miss on the replay cannot be fixed by another fill; report it as a miss.
          if (set_hit || replay_q) begin
            state_d = ST_RESP;
          end else begin
            miss_d  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          fill_d  = mem_rdata;
          state_d = ST_VICTIM;
        end
      end
      ST_VICTIM: begin
        if (vsel_valid) begin
          victim_d = vsel_way;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: state_d = ST_WAIT_FILL;
      ST_WAIT_FILL: begin
        if (set_done) begin
          replay_d = 1'b1;
          state_d  = ST_LOOKUP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      size_q   <= SZ_8;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fill_q   <= '0;
      victim_q <= '0;
      miss_q   <= 1'b0;
      replay_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      fill_q   <= fill_d;
      victim_q <= victim_d;
      miss_q   <= miss_d;
      replay_q <= replay_d;
    end
  end

  clock_victim_sel u_victim (
    .clk            (clk),
    .rst_n          (rst_n),
    .idx_i          (addr_q[OFF_W +: IDX_W]),
    .hit_touch_i    (state_q == ST_WAIT_SET && set_done && set_hit),
    .hit_way_i      (set_hit_way),
    .fill_touch_i   (state_q == ST_FILL),
    .fill_way_i     (victim_q),
    .start_i        (state_q == ST_VICTIM),
    .victim_o       (vsel_way),
    .victim_valid_o (vsel_valid)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign set_en     = (state_q == ST_LOOKUP) || (state_q == ST_FILL);
  assign set_force  = (state_q == ST_FILL) || (state_q == ST_WAIT_FILL);
  assign set_we     = we_q && ((state_q == ST_LOOKUP) || (state_q == ST_WAIT_SET));
  assign set_way    = victim_q;
  assign set_tag    = addr_q[OFF_W+IDX_W +: TAG_W];
  assign set_idx    = addr_q[OFF_W +: IDX_W];
  assign set_off    = addr_q[OFF_W-1:0];
  assign set_size   = size_q;
  assign set_wdata  = wdata_q;
  assign set_fill   = fill_q;
  assign mem_req    = (state_q == ST_FETCH);
  assign mem_addr   = addr_q[ADDR_W-1:OFF_W];
  assign resp_valid = (state_q == ST_RESP);
  assign resp_miss  = (state_q == ST_RESP) && miss_q;
  assign resp_rdata = (state_q == ST_RESP && !we_q) ? rdata_q : '0;

  a_no_replay_miss : assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == ST_WAIT_SET && set_done && !set_hit && replay_q));

endmodule
